// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: parametrised next-PC select with branch,
// jump, call/return through a circular return-address stack, and a trap vector.
module pc_sequencer #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(16'hFFF0),
    parameter int unsigned     RAS_DEPTH = 4,
    parameter bit              BR_REL    = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic [WIDTH-1:0]                   imm,
    input  logic [WIDTH-1:0]                   alu_out,
    output logic [WIDTH-1:0]                   pc_out,
    output logic [WIDTH-1:0]                   pc_next,
    output logic [WIDTH-1:0]                   link_addr,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_err
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ    = 3'b000,
        OP_BRANCH = 3'b001,
        OP_JUMP   = 3'b010,
        OP_JALR   = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101,
        OP_TRAP   = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    logic [WIDTH-1:0] pc_q;
    logic [PTR_W-1:0] tp_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic [WIDTH-1:0] pc_seq;
    logic [PTR_W-1:0] tp_inc;
    logic [PTR_W-1:0] tp_dec;
    logic             ras_full;
    logic             ras_empty;
    logic             push;
    logic             pop;
    logic             err_set;

    assign pc_seq    = pc_q + WIDTH'(STEP);
    assign link_addr = pc_seq;
    assign pc_out    = pc_q;
    assign ras_count = count_q;
    assign ras_err   = err_q;
    assign ras_full  = (count_q == CNT_W'(RAS_DEPTH));
    assign ras_empty = (count_q == '0);

    // Circular top-pointer neighbours; depth need not be a power of two.
    assign tp_inc = (tp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : tp_q + PTR_W'(1);
    assign tp_dec = (tp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : tp_q - PTR_W'(1);

    // Next-PC select and RAS control; stall freezes everything.
    always_comb begin
        pc_next = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (!stall) begin
            case (op_e'(op))
                OP_BRANCH: pc_next = BR_REL ? (pc_q + imm) : imm;
                OP_JUMP:   pc_next = imm;
                OP_JALR:   pc_next = alu_out;
                OP_CALL: begin
                    pc_next = imm;
                    push    = 1'b1;
                    err_set = ras_full;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        pc_next = pc_seq;
                        err_set = 1'b1;
                    end else begin
                        pc_next = ras_mem[tp_q];
                        pop     = 1'b1;
                    end
                end
                OP_TRAP:   pc_next = TRAP_VEC;
                default:   pc_next = pc_seq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            tp_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (push) begin
                tp_q <= tp_inc;
                if (!ras_full) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (pop) begin
                tp_q    <= tp_dec;
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; a full stack overwrites its oldest slot.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ras_mem[tp_inc] <= pc_seq;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the fetch stage. It supersedes the fixed 16-bit PC with configurable width and step, a stall input, relative and absolute branch modes, call/return support through an internal circular return-address stack (RAS), and a trap vector. It drives the fetch address and the link address consumed by the register-file writeback path.

Parameters:
WIDTH, 16, PC / address width in bits
STEP, 1, sequential increment (1 = word-addressed memory)
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 16'hFFF0 truncated/zero-extended to WIDTH, target of TRAP op
RAS_DEPTH, 4, return-address stack entries (>=2)
BR_REL, 1, 1 = BRANCH target is pc+imm; 0 = BRANCH target is imm

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
stall  in  1  hold PC and RAS this cycle
op  in  3  next-PC select: 000 SEQ, 001 BRANCH, 010 JUMP, 011 JALR, 100 CALL, 101 RET, 110 TRAP, 111 reserved (= SEQ)
imm  in  WIDTH  immediate / branch offset (two's complement when relative)
alu_out  in  WIDTH  JALR target
pc_out  out  WIDTH  current PC (registered)
pc_next  out  WIDTH  combinational value PC will take at next edge
link_addr  out  WIDTH  pc_out+STEP, combinational
ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
ras_err  out  1  sticky: set on RAS underflow or overflow

Behaviour:
- Reset (sync, wins over everything incl. stall): pc<=RESET_VEC; ras_count<=0; RAS pointer<=0; ras_err<=0. RAS entry contents are don't-care.
- All arithmetic is modulo 2^WIDTH; wrap-around is silent (no flag).
- pc_next by op (when stall=0):
  SEQ/reserved: pc+STEP
  BRANCH: BR_REL ? pc+imm : imm
  JUMP: imm
  JALR: alu_out
  CALL: imm; push pc+STEP onto the RAS
  RET: RAS top; pop. If ras_count==0: pc_next=pc+STEP, no pop, ras_err<=1
  TRAP: TRAP_VEC; RAS unchanged
- stall=1: pc_next=pc; op is ignored; RAS and ras_count unchanged; no error set.
- PC updates at posedge with pc_next; single-cycle latency from op to pc_out.
- RAS is circular, with top pointer tp:
  push writes entry[tp+1 mod D], then tp++; ras_count=min(count+1, D).
  Push when count==D overwrites the oldest entry; count stays D; ras_err<=1.
  pop returns entry[tp], then tp--; count--.
- Back-to-back CALL/RET each cycle is supported with no bubble. RET in the cycle after CALL returns the just-pushed address.
- link_addr is valid for CALL and JALR writeback in the same cycle.
- ras_err clears only on reset.

Test Plan:
- Reset then 4 cycles of SEQ, WIDTH=16 STEP=1 -> pc_out 0,1,2,3,4; ras_count=0; ras_err=0.
- pc=0x0010, BRANCH imm=0xFFFC (BR_REL=1) -> pc_out=0x000C. Repeat with BR_REL=0 -> pc_out=0xFFFC. JALR alu_out=0x1234 -> 0x1234. TRAP -> TRAP_VEC.
- pc=0x0020, CALL imm=0x0100 -> pc=0x0100, ras_count=1, link_addr was 0x0021. Then SEQ ×2, then RET -> pc=0x0021, ras_count=0.
- Five nested CALLs with RAS_DEPTH=4 (return addresses a1..a5) -> ras_count=4, ras_err=1. Four RETs -> a5,a4,a3,a2. Fifth RET -> pc+1, ras_err stays 1.
- stall=1 held 3 cycles with op=CALL -> pc_out, ras_count, pc_next unchanged. Release with op=SEQ -> pc+1.
- Wrap and reset: pc=0xFFFF with SEQ -> 0x0000. Reset asserted together with stall=1 and op=RET -> pc=RESET_VEC, ras_count=0, ras_err=0 next cycle.
